// File: rtl/dqs_dly_sweep_if.sv
// rtl/dqs_dly_sweep_if.sv - delay-line control/feedback bus between the sweep sequencer and the DQS delay/IOB stage
interface dqs_dly_sweep_if #(
  parameter int DLY_WIDTH = 5
);
  logic [DLY_WIDTH-1:0] dly_data;
  logic                 ld;
  logic                 set;
  logic                 dly_ready;
  logic                 dqs_in;

  // Sequencer side: drives tap code and strobes, observes ready and the received DQS
  modport master (
    output dly_data, ld, set,
    input  dly_ready, dqs_in
  );

  // Delay/IOB stage side
  modport slave (
    input  dly_data, ld, set,
    output dly_ready, dqs_in
  );
endinterface

// File: rtl/dqs_dly_sweep.sv
// rtl/dqs_dly_sweep.sv - DQS ODELAY tap sweep with per-tap majority sampling and edge search
module dqs_dly_sweep #(
  parameter int DLY_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  dqs_dly_sweep_if.master      dly,
  output logic                 busy,
  output logic                 done,
  output logic                 edge_found,
  output logic [DLY_WIDTH-1:0] edge_tap,
  output logic                 ref_level,
  output logic                 err
);

  localparam int ONES_W = $clog2(SAMPLE_COUNT + 1);
  localparam logic [DLY_WIDTH-1:0] TAP_MAX     = '1;
  localparam logic [DLY_WIDTH-1:0] TAP_ONE     = DLY_WIDTH'(1);
  localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]           SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, SETTLE, SAMPLE, EVAL, FINISH} state_t;

  state_t              state, state_nxt;
  logic [DLY_WIDTH-1:0] tap;
  logic [7:0]          cnt;
  logic [ONES_W-1:0]   ones;
  logic [ONES_W:0]     ones_x2;
  logic                level;
  logic                fault;
  logic                ld_c, set_c, done_c;

  // Strict majority; an exact half count resolves to 0
  assign ones_x2 = {ones, 1'b0};
  assign level   = (32'(ones_x2) > 32'(SAMPLE_COUNT));

  // Abort or loss of ready kills any in-progress sweep step; IDLE and FINISH are immune
  assign fault = (state inside {LOAD, APPLY, SETTLE, SAMPLE, EVAL}) && (abort || !dly.dly_ready);

  assign dly.dly_data = tap;
  assign dly.ld       = ld_c;
  assign dly.set      = set_c;
  assign done         = done_c;
  assign busy         = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and strobe decode; a fault overrides everything including the EVAL decision
  always_comb begin
    state_nxt = state;
    ld_c      = 1'b0;
    set_c     = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE:    if (start && dly.dly_ready && !abort) state_nxt = LOAD;
      LOAD:    begin ld_c = 1'b1; state_nxt = APPLY; end
      APPLY:   begin set_c = 1'b1; state_nxt = SETTLE; end
      SETTLE:  if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  if (cnt == SAMPLE_LAST) state_nxt = EVAL;
      EVAL: begin
        if ((tap != '0) && (level != ref_level)) state_nxt = FINISH;
        else if (tap == TAP_MAX)                 state_nxt = FINISH;
        else                                     state_nxt = LOAD;
      end
      FINISH:  begin done_c = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    if (fault) begin
      state_nxt = FINISH;
      ld_c      = 1'b0;
      set_c     = 1'b0;
    end
  end

  // Tap, counters and sticky results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap        <= '0;
      cnt        <= '0;
      ones       <= '0;
      edge_found <= 1'b0;
      edge_tap   <= '0;
      ref_level  <= 1'b0;
      err        <= 1'b0;
    end else if (fault) begin
      err <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && dly.dly_ready && !abort) begin
            tap        <= '0;
            cnt        <= '0;
            ones       <= '0;
            edge_found <= 1'b0;
            edge_tap   <= '0;
            ref_level  <= 1'b0;
            err        <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt  <= '0;
            ones <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          ones <= ones + ONES_W'(dly.dqs_in);
          if (cnt == SAMPLE_LAST) cnt <= '0;
          else                    cnt <= cnt + 8'd1;
        end
        EVAL: begin
          if (tap == '0) begin
            ref_level <= level;
            tap       <= tap + TAP_ONE;
          end else if (level != ref_level) begin
            edge_found <= 1'b1;
            edge_tap   <= tap;
          end else if (tap == TAP_MAX) begin
            edge_tap <= tap;
          end else begin
            tap <= tap + TAP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dqs_dly_sweep.sv
// tb/tb_dqs_dly_sweep.sv - directed bench for the DQS delay sweep sequencer
module tb_dqs_dly_sweep;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       busy, done, edge_found, ref_level, err;
  logic [4:0] edge_tap;

  dqs_dly_sweep_if #(.DLY_WIDTH(5)) dly_bus ();

  dqs_dly_sweep #(.DLY_WIDTH(5), .SETTLE_CYCLES(8), .SAMPLE_COUNT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dly        (dly_bus),
    .busy       (busy),
    .done       (done),
    .edge_found (edge_found),
    .edge_tap   (edge_tap),
    .ref_level  (ref_level),
    .err        (err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mode = 0;

  int cyc = 0;
  int ld_count, set_count, seq_err, done_count, first_ld, done_cyc;
  logic prev_ld = 1'b0;

  // dqs_in pattern generator: 0 = low, 1 = high below tap 10, 2 = toggle every cycle
  always @(negedge clk) begin
    case (mode)
      1:       dly_bus.dqs_in = (dly_bus.dly_data < 5'd10);
      2:       dly_bus.dqs_in = ~dly_bus.dqs_in;
      default: dly_bus.dqs_in = 1'b0;
    endcase
  end

  // Strobe monitor: ld data sequence, ld->set ordering, done timing
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dly_bus.ld === 1'b1) begin
      if (ld_count == 0) first_ld = cyc;
      if (dly_bus.dly_data !== 5'(ld_count)) seq_err = seq_err + 1;
      ld_count = ld_count + 1;
    end
    if (dly_bus.set === 1'b1) begin
      if (prev_ld !== 1'b1) seq_err = seq_err + 1;
      set_count = set_count + 1;
    end
    if (dly_bus.ld === 1'b1 && dly_bus.set === 1'b1) seq_err = seq_err + 1;
    if (done === 1'b1) begin
      done_cyc   = cyc;
      done_count = done_count + 1;
    end
    prev_ld = dly_bus.ld;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mon_clear();
    ld_count = 0; set_count = 0; seq_err = 0; done_count = 0; first_ld = 0; done_cyc = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) break;
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL %s.done_timeout got done=%0b after %0d cycles want 1", name, done, budget);
    else pass_cnt++;
  endtask

  task automatic wait_ld(input string name, input int n);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (ld_count >= n) break;
      step();
    end
    total_cnt++;
    if (ld_count < n) $display("FAIL %s.ld_wait got %0d loads want %0d", name, ld_count, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy, done, dly_bus.ld, dly_bus.set, edge_found, ref_level, err} !== 7'b0)
      $display("FAIL reset.flags got %b want 0000000", {busy, done, dly_bus.ld, dly_bus.set, edge_found, ref_level, err});
    else pass_cnt++;
    total_cnt++;
    if ({dly_bus.dly_data, edge_tap} !== 10'd0)
      $display("FAIL reset.codes got dly_data=%0d edge_tap=%0d want 0 0", dly_bus.dly_data, edge_tap);
    else pass_cnt++;
  endtask

  task automatic test_no_edge();
    mode = 0; mon_clear();
    pulse_start();
    wait_done("no_edge", 1000);
    total_cnt++; if (ld_count !== 32) $display("FAIL no_edge.ld_count got %0d want 32", ld_count); else pass_cnt++;
    total_cnt++; if (set_count !== 32) $display("FAIL no_edge.set_count got %0d want 32", set_count); else pass_cnt++;
    total_cnt++; if (seq_err !== 0) $display("FAIL no_edge.seq_err got %0d want 0", seq_err); else pass_cnt++;
    total_cnt++; if (done_cyc - first_ld !== 864) $display("FAIL no_edge.latency got %0d want 864", done_cyc - first_ld); else pass_cnt++;
    total_cnt++; if (edge_found !== 1'b0) $display("FAIL no_edge.edge_found got %0b want 0", edge_found); else pass_cnt++;
    total_cnt++; if (edge_tap !== 5'd31) $display("FAIL no_edge.edge_tap got %0d want 31", edge_tap); else pass_cnt++;
    total_cnt++; if (ref_level !== 1'b0) $display("FAIL no_edge.ref_level got %0b want 0", ref_level); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL no_edge.err got %0b want 0", err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL no_edge.busy_at_done got %0b want 1", busy); else pass_cnt++;
    step();
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL no_edge.after_done got busy,done=%b want 00", {busy, done}); else pass_cnt++;
  endtask

  task automatic test_edge();
    mode = 1; mon_clear();
    pulse_start();
    wait_done("edge", 1000);
    total_cnt++; if (ref_level !== 1'b1) $display("FAIL edge.ref_level got %0b want 1", ref_level); else pass_cnt++;
    total_cnt++; if (edge_found !== 1'b1) $display("FAIL edge.edge_found got %0b want 1", edge_found); else pass_cnt++;
    total_cnt++; if (edge_tap !== 5'd10) $display("FAIL edge.edge_tap got %0d want 10", edge_tap); else pass_cnt++;
    total_cnt++; if (done_cyc - first_ld !== 297) $display("FAIL edge.latency got %0d want 297", done_cyc - first_ld); else pass_cnt++;
    total_cnt++; if (ld_count !== 11) $display("FAIL edge.ld_count got %0d want 11", ld_count); else pass_cnt++;
    step();
  endtask

  task automatic test_tie();
    mode = 2; mon_clear();
    pulse_start();
    wait_done("tie", 1000);
    total_cnt++; if (ref_level !== 1'b0) $display("FAIL tie.ref_level got %0b want 0", ref_level); else pass_cnt++;
    total_cnt++; if (edge_found !== 1'b0) $display("FAIL tie.edge_found got %0b want 0", edge_found); else pass_cnt++;
    total_cnt++; if (edge_tap !== 5'd31) $display("FAIL tie.edge_tap got %0d want 31", edge_tap); else pass_cnt++;
    step();
    mode = 0;
  endtask

  task automatic test_not_ready();
    mode = 0; mon_clear();
    dly_bus.dly_ready = 1'b0;
    pulse_start();
    repeat (4) step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL not_ready.busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (ld_count !== 0) $display("FAIL not_ready.ld_count got %0d want 0", ld_count); else pass_cnt++;
    total_cnt++; if ({err, done_count[0]} !== 2'b00) $display("FAIL not_ready.err_done got %b want 00", {err, done_count[0]}); else pass_cnt++;
    dly_bus.dly_ready = 1'b1;
    mon_clear();
    pulse_start();
    wait_ld("ready_loss", 6);
    repeat (12) step();
    dly_bus.dly_ready = 1'b0;
    step();
    total_cnt++; if ({done, err, busy} !== 3'b111) $display("FAIL ready_loss.finish got done,err,busy=%b want 111", {done, err, busy}); else pass_cnt++;
    total_cnt++; if (dly_bus.dly_data !== 5'd5) $display("FAIL ready_loss.tap_held got %0d want 5", dly_bus.dly_data); else pass_cnt++;
    step();
    total_cnt++; if ({busy, done, err} !== 3'b001) $display("FAIL ready_loss.after got busy,done,err=%b want 001", {busy, done, err}); else pass_cnt++;
    dly_bus.dly_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    mode = 0; mon_clear();
    pulse_start();
    wait_ld("restart", 4);
    pulse_start();
    wait_done("restart", 1000);
    total_cnt++; if (ld_count !== 32) $display("FAIL restart.ld_count got %0d want 32", ld_count); else pass_cnt++;
    total_cnt++; if (seq_err !== 0) $display("FAIL restart.seq_err got %0d want 0", seq_err); else pass_cnt++;
    total_cnt++; if (done_cyc - first_ld !== 864) $display("FAIL restart.latency got %0d want 864", done_cyc - first_ld); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL restart.err got %0b want 0", err); else pass_cnt++;
    step();
    mon_clear();
    pulse_start();
    wait_ld("abort", 1);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total_cnt++; if ({done, err, edge_found} !== 3'b110) $display("FAIL abort.finish got done,err,edge_found=%b want 110", {done, err, edge_found}); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (ld_count !== 1 || busy !== 1'b0) $display("FAIL abort.stopped got ld_count=%0d busy=%0b want 1 0", ld_count, busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mode = 0; mon_clear();
    pulse_start();
    wait_ld("reset_mid", 8);
    repeat (12) step();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, dly_bus.ld, dly_bus.set, edge_found, ref_level, err, dly_bus.dly_data, edge_tap} !== 17'd0)
      $display("FAIL reset_mid.outputs got busy=%0b dly_data=%0d edge_tap=%0d err=%0b want all 0", busy, dly_bus.dly_data, edge_tap, err);
    else pass_cnt++;
    repeat (2) step();
    rst = 1'b1;
    step();
    mon_clear();
    pulse_start();
    wait_done("reset_mid", 1000);
    total_cnt++; if (ld_count !== 32 || seq_err !== 0) $display("FAIL reset_mid.resweep got ld_count=%0d seq_err=%0d want 32 0", ld_count, seq_err); else pass_cnt++;
    step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    dly_bus.dly_ready = 1'b1;
    dly_bus.dqs_in = 1'b0;
    mon_clear();
    repeat (3) step();
    test_reset();
    rst = 1'b1;
    step();
    test_no_edge();
    test_edge();
    test_tie();
    test_not_ready();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dqs_dly_sweep.md
Name: dqs_dly_sweep

Overview:
Calibration sequencer for the DQS output-delay path. It steps the 5-bit ODELAY tap code through 0..31 and drives the delay line's load/apply strobes (dly_data, ld, set) for each tap. At each tap it majority-samples the looped-back DQS receiver output and reports the first tap where the sampled level flips. It runs in the clk_div domain and sits directly upstream of the DQS delay/IOB test stage, consuming that stage's dqs_received and dly_ready outputs.

Parameters:
DLY_WIDTH, 5, tap code width; sweep covers 0..2^DLY_WIDTH-1
SETTLE_CYCLES, 8, idle cycles after set before sampling (1..255)
SAMPLE_COUNT, 16, samples taken per tap (1..255)

Ports:
clk  in  1  sweep clock (clk_div domain of the delay lines)
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a sweep
abort  in  1  level; forces return to IDLE
dly_ready  in  1  IDELAYCTRL ready (already qualified)
dqs_in  in  1  received DQS sample, already synchronous to clk
dly_data  out  DLY_WIDTH  tap code to delay line
ld  out  1  load strobe, one cycle per tap
set  out  1  apply strobe, one cycle per tap, cycle after ld
busy  out  1  high from sweep acceptance until DONE is left
done  out  1  one-cycle pulse at sweep end (edge found, exhausted, or error)
edge_found  out  1  sticky result: level flip detected
edge_tap  out  DLY_WIDTH  first tap whose level differs from tap 0
ref_level  out  1  majority level measured at tap 0
err  out  1  sticky: sweep aborted (abort or dly_ready loss)

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, tap=0, counters 0.
- FSM states: IDLE, LOAD, APPLY, SETTLE, SAMPLE, EVAL, FINISH.
- IDLE: start=1 && dly_ready=1 && abort=0 -> LOAD. On entry, clear edge_found/err/edge_tap/ref_level, set tap=0, set busy=1. start is ignored when dly_ready=0 (no busy, no err).
- LOAD (1 cycle): dly_data=tap, ld=1 -> APPLY.
- APPLY (1 cycle): set=1 -> SETTLE. dly_data holds the tap value until the next LOAD.
- SETTLE: count SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE: SAMPLE_COUNT cycles; ones counter += dqs_in. Counter width is clog2(SAMPLE_COUNT+1). The counter clears on entry.
- EVAL (1 cycle): level = (2*ones > SAMPLE_COUNT); ties resolve to 0.
  - tap 0: ref_level <= level; tap += 1 -> LOAD.
  - tap > 0 and level != ref_level: edge_found=1, edge_tap=tap -> FINISH.
  - tap = max and no flip: edge_found=0, edge_tap=max -> FINISH.
  - else tap += 1 -> LOAD.
- Per-tap latency: SETTLE_CYCLES+SAMPLE_COUNT+3 cycles (27 at defaults). With no edge, done asserts 32*27 = 864 cycles after the first LOAD cycle.
- FINISH (1 cycle): done=1, busy=0 on the next cycle -> IDLE.
- abort=1 or dly_ready=0 in any non-IDLE, non-FINISH state: err=1, ld=0, set=0 immediately, -> FINISH. Tap code is not reset. An abort in the same cycle as EVAL takes priority over the EVAL result.
- start while busy: ignored.
- Tap counter never wraps; sweep ends at max.
- ld and set are never high in the same cycle. Each is high exactly once per tap.

Test Plan:
- dqs_in held 0, dly_ready=1, pulse start -> 32 ld/set pairs with dly_data 0..31; done at cycle 864 after first ld; edge_found=0, edge_tap=31, ref_level=0, err=0.
- dqs_in=1 while dly_data<10, else 0 -> ref_level=1, edge_found=1, edge_tap=10, done after 11 taps (297 cycles).
- dqs_in toggling every cycle at every tap (8 of 16 ones) -> ties resolve 0 at all taps; edge_found=0.
- dly_ready=0 with start pulse -> busy stays 0, no ld, err=0; then drop dly_ready during tap 5 SAMPLE -> err=1, done pulse next cycle, busy=0.
- start pulsed again mid-sweep at tap 3 -> ignored; sweep completes unchanged. Then abort during SETTLE -> err=1, edge_found=0.
- Assert rst low mid-SAMPLE at tap 7 -> all outputs 0 asynchronously. After release, a new start sweeps from tap 0.
